// File: rtl/m92_irq_ctrl.sv
// m92_irq_ctrl: parametrised interrupt controller for the V30 main CPU.
// Latches NUM_INT sources (edge or level per line), resolves fixed or
// rotating priority against the in-service set, and drives a registered
// request/vector pair to the CPU core, which acknowledges with int_ack.
module m92_irq_ctrl #(
  parameter int NUM_INT = 8,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               cs,
  input  logic               wr,
  input  logic [2:0]         addr,
  input  logic [7:0]         din,
  input  logic [NUM_INT-1:0] intp,
  output logic               int_req,
  output logic [8:0]         int_vector,
  input  logic               int_ack
);

  localparam int unsigned N = NUM_INT;
  localparam logic [NUM_INT-1:0] LSB_ONE = NUM_INT'(1);
  localparam logic [IDX_W-1:0]   LOWEST_RST = IDX_W'(NUM_INT - 1);

  typedef enum logic [2:0] {
    A_BASE    = 3'd0,
    A_MASK_LO = 3'd1,
    A_MASK_HI = 3'd2,
    A_LVL_LO  = 3'd3,
    A_LVL_HI  = 3'd4,
    A_CMD     = 3'd5,
    A_RSV6    = 3'd6,
    A_RSV7    = 3'd7
  } reg_addr_e;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------

  function automatic logic [NUM_INT-1:0] onehot(input logic [IDX_W-1:0] idx);
    return LSB_ONE << idx;
  endfunction

  function automatic logic bit_at(input logic [NUM_INT-1:0] v,
                                  input logic [IDX_W-1:0]   idx);
    return |(v & onehot(idx));
  endfunction

  // Line that currently holds top priority: 0 when fixed, lowest+1 (wrapping)
  // when rotating.
  function automatic logic [IDX_W-1:0] start_of(input logic             rot,
                                                input logic [IDX_W-1:0] low);
    logic [IDX_W-1:0] s;
    s = '0;
    if (rot && (32'(low) < N - 1)) s = IDX_W'(32'(low) + 1);
    return s;
  endfunction

  // Highest-priority set bit of v, scanning cyclically from start.
  // Result is {found, index}.
  function automatic logic [IDX_W:0] pick(input logic [NUM_INT-1:0] v,
                                          input logic [IDX_W-1:0]   start);
    logic             found;
    logic [IDX_W-1:0] idx;
    int unsigned      j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned r = 0; r < N; r++) begin
      j = 32'(start) + r;
      if (j >= N) j = j - N;
      if (!found && |(v & (LSB_ONE << j))) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

  // Cyclic distance from the top-priority line; smaller means more urgent.
  function automatic int unsigned rank(input logic [IDX_W-1:0] idx,
                                       input logic [IDX_W-1:0] start);
    int unsigned i;
    int unsigned s;
    i = 32'(idx);
    s = 32'(start);
    return (i >= s) ? (i - s) : (i + N - s);
  endfunction

  // Replace one byte of a NUM_INT-wide register; bits at or above NUM_INT
  // fall away in the final truncation.
  function automatic logic [NUM_INT-1:0] put_byte(input logic [NUM_INT-1:0] cur,
                                                  input logic               hi,
                                                  input logic [7:0]         d);
    logic [15:0] be;
    be = hi ? 16'hFF00 : 16'h00FF;
    return NUM_INT'((16'(cur) & ~be) | ({d, d} & be));
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------

  logic [NUM_INT-1:0] irr_q,   irr_d;
  logic [NUM_INT-1:0] isr_q,   isr_d;
  logic [NUM_INT-1:0] mask_q,  mask_d;
  logic [NUM_INT-1:0] level_q, level_d;
  logic [NUM_INT-1:0] prev_q,  prev_d;
  logic [7:0]         base_q,  base_d;
  logic               auto_eoi_q, auto_eoi_d;
  logic               rotate_q,   rotate_d;
  logic [IDX_W-1:0]   lowest_q,   lowest_d;
  logic               int_req_q,  int_req_d;
  logic [7:0]         int_vector_q, int_vector_d;

  reg_addr_e          ra;
  logic               wr_en;
  logic               cmd_wr;

  logic [IDX_W-1:0]   cur_start;
  logic               c_found;
  logic [IDX_W-1:0]   c_idx;
  logic               ack_v;
  logic [NUM_INT-1:0] ack_clr;
  logic [NUM_INT-1:0] isr_ack;
  logic [IDX_W-1:0]   lowest_ack;

  logic               spec_req;
  logic               ns_req;
  logic               spec_in_range;
  logic [IDX_W-1:0]   spec_idx;
  logic               e_found;
  logic [IDX_W-1:0]   e_idx;
  logic               eoi_hit;
  logic [IDX_W-1:0]   eoi_idx;

  logic [IDX_W-1:0]   view_start;
  logic               v_found;
  logic [IDX_W-1:0]   v_idx;
  logic               b_found;
  logic [IDX_W-1:0]   b_idx;

  assign ra     = reg_addr_e'(addr);
  assign wr_en  = ce & cs & wr;
  assign cmd_wr = wr_en && (ra == A_CMD);

  assign int_req    = int_req_q;
  assign int_vector = {1'b0, int_vector_q};

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------

  // Register-file writes; take effect on the following clk.
  always_comb begin
    base_d     = base_q;
    mask_d     = mask_q;
    level_d    = level_q;
    auto_eoi_d = auto_eoi_q;
    rotate_d   = rotate_q;
    if (wr_en) begin
      unique case (ra)
        A_BASE:    base_d  = din;
        A_MASK_LO: mask_d  = put_byte(mask_q, 1'b0, din);
        A_MASK_HI: mask_d  = put_byte(mask_q, 1'b1, din);
        A_LVL_LO:  level_d = put_byte(level_q, 1'b0, din);
        A_LVL_HI:  level_d = put_byte(level_q, 1'b1, din);
        A_CMD: begin
          auto_eoi_d = din[5];
          rotate_d   = din[4];
        end
        A_RSV6, A_RSV7: ;
        default: ;
      endcase
    end
  end

  // Acknowledge: take the current candidate, retire its edge request and
  // move it in service (or rotate straight away under auto-EOI).
  always_comb begin
    cur_start          = start_of(rotate_q, lowest_q);
    {c_found, c_idx}   = pick(irr_q & ~mask_q, cur_start);
    ack_v              = int_ack & int_req_q & c_found;
    ack_clr            = '0;
    isr_ack            = isr_q;
    lowest_ack         = lowest_q;
    if (ack_v) begin
      if (!bit_at(level_q, c_idx)) ack_clr = onehot(c_idx);
      if (!auto_eoi_q) isr_ack = isr_q | onehot(c_idx);
      else if (rotate_q) lowest_ack = c_idx;
    end
  end

  // End of interrupt, applied on top of the same-cycle acknowledge.
  always_comb begin
    spec_req         = cmd_wr & din[7];
    ns_req           = cmd_wr & ~din[7] & din[6];
    spec_in_range    = 32'(din[3:0]) < N;
    spec_idx         = IDX_W'(din[3:0]);
    {e_found, e_idx} = pick(isr_ack, start_of(rotate_q, lowest_ack));
    eoi_hit          = 1'b0;
    eoi_idx          = '0;
    if (spec_req) begin
      if (spec_in_range && bit_at(isr_ack, spec_idx)) begin
        eoi_hit = 1'b1;
        eoi_idx = spec_idx;
      end
    end else if (ns_req && e_found) begin
      eoi_hit = 1'b1;
      eoi_idx = e_idx;
    end
    isr_d    = eoi_hit ? (isr_ack & ~onehot(eoi_idx)) : isr_ack;
    lowest_d = (eoi_hit && rotate_q) ? eoi_idx : lowest_ack;
  end

  // Request latch: edge lines set on a rising sample and clear on ack (a
  // fresh edge in the ack cycle wins); level lines follow the input.
  always_comb begin
    irr_d  = irr_q & ~ack_clr;
    prev_d = prev_q;
    if (ce) begin
      irr_d  = (irr_d & ~level_q) | (intp & ~prev_q & ~level_q) | (intp & level_q);
      prev_d = intp;
    end
  end

  // Output view: evaluated on the post-ack/post-EOI service state but on
  // the requests already latched, so an ack drops int_req one clk later
  // while a new edge still needs two.
  always_comb begin
    view_start       = start_of(rotate_q, lowest_d);
    {v_found, v_idx} = pick(irr_q & ~ack_clr & ~mask_q, view_start);
    {b_found, b_idx} = pick(isr_d, view_start);
    int_req_d        = v_found &&
                       !(b_found && (rank(b_idx, view_start) <= rank(v_idx, view_start)));
    int_vector_d     = int_req_d ? (base_q + 8'(v_idx)) : int_vector_q;
  end

  // State register with synchronous active-low reset (not ce-gated).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irr_q        <= '0;
      isr_q        <= '0;
      prev_q       <= '0;
      mask_q       <= '1;
      level_q      <= '0;
      base_q       <= '0;
      auto_eoi_q   <= 1'b0;
      rotate_q     <= 1'b0;
      lowest_q     <= LOWEST_RST;
      int_req_q    <= 1'b0;
      int_vector_q <= '0;
    end else begin
      irr_q        <= irr_d;
      isr_q        <= isr_d;
      prev_q       <= prev_d;
      mask_q       <= mask_d;
      level_q      <= level_d;
      base_q       <= base_d;
      auto_eoi_q   <= auto_eoi_d;
      rotate_q     <= rotate_d;
      lowest_q     <= lowest_d;
      int_req_q    <= int_req_d;
      int_vector_q <= int_vector_d;
    end
  end

endmodule

// File: tb/tb_m92_irq_ctrl.sv
// Directed self-checking bench for m92_irq_ctrl (NUM_INT=8).
// All stimulus changes and all sampling happen on the falling clk edge.
module tb_m92_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       cs;
  logic       wr;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] intp;
  logic       int_req;
  logic [8:0] int_vector;
  logic       int_ack;

  int checks = 0;
  int errors = 0;

  m92_irq_ctrl #(.NUM_INT(8), .IDX_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .cs         (cs),
    .wr         (wr),
    .addr       (addr),
    .din        (din),
    .intp       (intp),
    .int_req    (int_req),
    .int_vector (int_vector),
    .int_ack    (int_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wreg(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; din = d;
    tick();
    cs = 1'b0; wr = 1'b0; addr = '0; din = '0;
  endtask

  task automatic edge_pulse(input logic [7:0] m);
    intp = m;
    tick();
    intp = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; cs = 1'b0; wr = 1'b0;
    addr = '0; din = '0; intp = '0; int_ack = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_req",    16'(int_req),        16'h0);
    chk("rst_vec",    16'(int_vector),     16'h000);
    chk("rst_isr",    16'(dut.isr_q),      16'h00);
    chk("rst_mask",   16'(dut.mask_q),     16'hFF);
    chk("rst_lowest", 16'(dut.lowest_q),   16'h7);
    reset_n = 1'b1;

    // Basic edge request on line 1, base 0x40
    wreg(3'd1, 8'h00);
    wreg(3'd0, 8'h40);
    edge_pulse(8'h02);
    chk("t1_req_latency", 16'(int_req), 16'h0);
    tick();
    chk("t1_req",   16'(int_req),    16'h1);
    chk("t1_vec",   16'(int_vector), 16'h041);
    ack();
    chk("t1_ack_req", 16'(int_req),   16'h0);
    chk("t1_ack_isr", 16'(dut.isr_q), 16'h02);
    chk("t1_ack_irr", 16'(dut.irr_q), 16'h00);
    wreg(3'd5, 8'h40);
    chk("t1_eoi_isr", 16'(dut.isr_q), 16'h00);

    // Lines 3 and 1 together; 3 blocked while 1 is in service
    edge_pulse(8'h0A);
    tick();
    chk("t2_req", 16'(int_req),    16'h1);
    chk("t2_vec", 16'(int_vector), 16'h041);
    ack();
    chk("t2_blocked",  16'(int_req),   16'h0);
    chk("t2_isr",      16'(dut.isr_q), 16'h02);
    tick();
    chk("t2_blocked2", 16'(int_req),   16'h0);
    wreg(3'd5, 8'h40);
    chk("t2_eoi_isr", 16'(dut.isr_q), 16'h00);
    chk("t2_eoi_req", 16'(int_req),   16'h1);
    chk("t2_eoi_vec", 16'(int_vector), 16'h043);
    ack();
    chk("t2_isr3", 16'(dut.isr_q), 16'h08);
    wreg(3'd5, 8'h40);

    // Level line 2 withdrawn before ack
    wreg(3'd3, 8'h04);
    intp = 8'h04;
    tick(); tick();
    chk("t3_req",  16'(int_req),    16'h1);
    chk("t3_vec",  16'(int_vector), 16'h042);
    intp = 8'h00;
    tick(); tick();
    chk("t3_drop_req",  16'(int_req),    16'h0);
    chk("t3_hold_vec",  16'(int_vector), 16'h042);
    chk("t3_isr",       16'(dut.isr_q),  16'h00);
    wreg(3'd3, 8'h00);

    // Auto-EOI with rotation
    wreg(3'd5, 8'h30);
    edge_pulse(8'h21);
    tick();
    chk("t4_vec0", 16'(int_vector), 16'h040);
    ack();
    chk("t4_req5",    16'(int_req),      16'h1);
    chk("t4_vec5",    16'(int_vector),   16'h045);
    chk("t4_isr",     16'(dut.isr_q),    16'h00);
    chk("t4_lowest0", 16'(dut.lowest_q), 16'h0);
    ack();
    chk("t4_lowest5", 16'(dut.lowest_q), 16'h5);
    chk("t4_req_off", 16'(int_req),      16'h0);
    edge_pulse(8'h41);
    tick();
    chk("t4_rot_vec6", 16'(int_vector), 16'h046);
    ack();
    chk("t4_lowest6",  16'(dut.lowest_q), 16'h6);
    chk("t4_rot_vec0", 16'(int_vector),   16'h040);
    ack();
    chk("t4_lowest_w", 16'(dut.lowest_q), 16'h0);
    wreg(3'd5, 8'h00);

    // Nested service, specific EOI out of range, specific beats non-specific
    edge_pulse(8'h10);
    tick();
    chk("t5_vec4", 16'(int_vector), 16'h044);
    ack();
    edge_pulse(8'h02);
    tick();
    chk("t5_nest_req", 16'(int_req),    16'h1);
    chk("t5_nest_vec", 16'(int_vector), 16'h041);
    ack();
    chk("t5_isr12", 16'(dut.isr_q), 16'h12);
    wreg(3'd5, 8'h89);
    chk("t5_eoi9_isr",    16'(dut.isr_q),    16'h12);
    chk("t5_eoi9_lowest", 16'(dut.lowest_q), 16'h0);
    wreg(3'd5, 8'hC4);
    chk("t5_spec_wins", 16'(dut.isr_q), 16'h02);
    wreg(3'd5, 8'h40);
    chk("t5_isr_clear", 16'(dut.isr_q), 16'h00);

    // Masking and ack while idle
    wreg(3'd1, 8'hFF);
    edge_pulse(8'h08);
    tick();
    chk("t6_masked_req", 16'(int_req),   16'h0);
    chk("t6_masked_irr", 16'(dut.irr_q), 16'h08);
    ack();
    chk("t6_idle_ack_irr", 16'(dut.irr_q), 16'h08);
    chk("t6_idle_ack_isr", 16'(dut.isr_q), 16'h00);
    wreg(3'd1, 8'h00);
    tick();
    chk("t6_unmask_req", 16'(int_req),    16'h1);
    chk("t6_unmask_vec", 16'(int_vector), 16'h043);

    // Reset during service, with ce low
    ack();
    edge_pulse(8'h04);
    tick();
    chk("t7_pre_req", 16'(int_req),    16'h1);
    chk("t7_pre_vec", 16'(int_vector), 16'h042);
    chk("t7_pre_isr", 16'(dut.isr_q),  16'h08);
    reset_n = 1'b0; ce = 1'b0;
    tick();
    chk("t7_req",    16'(int_req),      16'h0);
    chk("t7_vec",    16'(int_vector),   16'h000);
    chk("t7_isr",    16'(dut.isr_q),    16'h00);
    chk("t7_irr",    16'(dut.irr_q),    16'h00);
    chk("t7_mask",   16'(dut.mask_q),   16'hFF);
    chk("t7_lowest", 16'(dut.lowest_q), 16'h7);
    chk("t7_base",   16'(dut.base_q),   16'h00);
    reset_n = 1'b1;

    // Writes need ce
    wreg(3'd0, 8'h80);
    chk("t8_ce_gate", 16'(dut.base_q), 16'h00);
    ce = 1'b1;
    wreg(3'd0, 8'h80);
    chk("t8_base", 16'(dut.base_q), 16'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m92_irq_ctrl.md
# m92_irq_ctrl

Parametrised interrupt controller for the V30 main CPU, the next-generation replacement for the fixed 8-input PIC. It latches up to NUM_INT interrupt sources, resolves priority against in-service state, and presents a request/vector pair to the CPU core's `irqrequest_in` / `irqvector_in` / `irqrequest_ack` port. New capabilities:
- per-line edge/level trigger select;
- per-line masking;
- specific and non-specific EOI;
- auto-EOI;
- rotating priority.

## Interface
- NUM_INT, 8: number of interrupt inputs, 1..16; line 0 is highest fixed priority.
- IDX_W, 4: index width, must satisfy 2**IDX_W >= NUM_INT.
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- ce  in  1  sampling enable; inputs and register writes act only when ce=1.
- cs  in  1  register select from IO decode.
- wr  in  1  write strobe, qualified by cs and ce.
- addr  in  3  register index.
- din  in  8  write data.
- intp  in  NUM_INT  raw interrupt sources, active high.
- int_req  out  1  pending unmasked request exists.
- int_vector  out  9  {1'b0, vector}, vector = (base + index) mod 256.
- int_ack  in  1  single-clk acknowledge from CPU core (not ce-gated).

## Operation
Register map (write-only), addr:
- 0: base (vector base).
- 1/2: mask[7:0] / mask[15:8]; 1 = masked.
- 3/4: level[7:0] / level[15:8]; 1 = level-triggered.
- 5: command.
  - din[7]=1: specific EOI on din[3:0].
  - din[6]=1: non-specific EOI.
  - din[5]: auto_eoi.
  - din[4]: rotate enable.
  - Bits 7 and 6 both set: specific EOI wins.
- 6, 7: reserved, writes ignored.
- Bits at or above NUM_INT in mask and level are not stored; they read as 0 internally.

State: irr, isr, mask, level, prev (all NUM_INT bits); base[7:0]; auto_eoi; rotate; lowest[IDX_W-1:0].

Request latch, on ce, per line i:
- Edge line: irr[i] set when intp[i] & ~prev[i]. Cleared only by ack.
- Level line: irr[i] = intp[i]. Drop before ack withdraws the request.
- prev updates every ce.

Priority:
- Fixed: line 0 highest.
- Rotating: line (lowest+1) mod NUM_INT highest, descending cyclically.
- cand = highest-priority bit of irr & ~mask.
- int_req = 1 iff cand exists and no isr bit has equal or higher priority than cand.
- int_vector tracks cand while int_req=1 and holds its last value otherwise.

Ack (int_ack=1, any cycle):
- Captures the current cand (k).
- Clears irr[k] for edge lines.
- Sets isr[k] unless auto_eoi.
- If auto_eoi and rotate: lowest <= k.
- Ack while int_req=0 is ignored.

EOI:
- Non-specific: clears the highest-priority set isr bit.
- Specific: clears isr[din[3:0]]; an index >= NUM_INT is ignored.
- If rotate: lowest <= the cleared index. No bit cleared: lowest unchanged.

Simultaneous events on the same clk:
- Edge on line k + ack of k: irr[k] remains set (new edge wins).
- Ack + EOI: ack applies first, then EOI.
- Write to mask + ack: ack uses the pre-write mask.

## Timing
- Reset values:
  - irr=0, isr=0, prev=0, mask=all 1, level=0.
  - base=0, auto_eoi=0, rotate=0, lowest=NUM_INT-1.
  - int_req=0, int_vector=0.
- Registered outputs: int_req and int_vector update on the clk after the state change.
- Latency:
  - Rising edge on intp sampled at ce cycle N: irr set at N+1, int_req high at N+2.
  - Ack at cycle M: int_req low at M+1 (unless another candidate qualifies, in which case the new vector is shown at M+1).
- Register writes take effect the clk after the ce&cs&wr cycle.
- Reset asserted mid-service clears all state on the next clk edge regardless of ce.

## Test plan
- Reset, write mask=0x00, base=0x40, pulse intp[1] → int_req=1 two ce later, int_vector=0x041; ack → int_req=0, isr=0x02.
- intp[3] and intp[1] edges same ce, ack, then non-specific EOI → first vector 0x041; after EOI, vector 0x043 appears; line 3 is blocked while isr[1] is set.
- Line 2 level mode, intp[2] high then low before ack → int_req rises then falls; no isr change.
- auto_eoi=1, rotate=1, edges on 0 and 5, ack 0 → isr stays 0, lowest=0; next candidate priority order 1..7,0, vector=base+5.
- Specific EOI index 9 with NUM_INT=8 → no state change; mask=0xFF with pending irr → int_req=0; mask cleared → int_req=1.
- reset_n low during int_req=1 with isr≠0 → next clk all state at reset values, int_vector=0.
